// File: rtl/bitmap_index_scanner_pkg.sv
// bitmap_index_scanner_pkg: shared scanner state type and index-width helper
package bitmap_index_scanner_pkg;

    typedef enum logic {IDLE, SCAN} state_t;

    function automatic int idx_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/bitmap_index_scanner_tz_count.sv
// tz_count: trailing-zero count of a word, DATA_WIDTH for an all-zero word
module tz_count
    import bitmap_index_scanner_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]          d,
    output logic [idx_w(DATA_WIDTH)-1:0]   count
);

    localparam int IW = idx_w(DATA_WIDTH);

    // scan from the top so the lowest set bit wins
    always_comb begin
        count = IW'(DATA_WIDTH);
        for (int i = DATA_WIDTH - 1; i >= 0; i--)
            if (d[i]) count = IW'(i);
    end

endmodule

// File: rtl/bitmap_index_scanner.sv
// bitmap_index_scanner: emits set-bit indices of each word lowest first; BITMAP_SCAN_EMPTY_REPORT_EN reports empty words
module bitmap_index_scanner
    import bitmap_index_scanner_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         din,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [idx_w(DATA_WIDTH)-1:0]  dout,
    output logic                          out_last,
    output logic                          busy
);

    state_t                  state, state_n;
    logic [DATA_WIDTH-1:0]   rem, rem_n, rem_clr;
    logic [idx_w(DATA_WIDTH)-1:0] tz;
    logic                    single, accept, xfer;

    tz_count #(.DATA_WIDTH(DATA_WIDTH)) u_tz (.d(rem), .count(tz));

    assign rem_clr   = rem & (rem - 1'b1);
    assign single    = (rem_clr == '0);
    assign busy      = (state == SCAN);
    assign out_valid = busy;
    assign dout      = busy ? tz : '0;
    assign in_ready  = !busy || (out_ready && out_last);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

`ifdef BITMAP_SCAN_EMPTY_REPORT_EN
    logic empty, empty_n;

    assign out_last = busy && (empty || single);

    // next state: a new word takes priority over retiring the current beat
    always_comb begin
        state_n = state;
        rem_n   = rem;
        empty_n = empty;
        if (accept) begin
            state_n = SCAN;
            rem_n   = din;
            empty_n = (din == '0);
        end else if (xfer) begin
            state_n = out_last ? IDLE : SCAN;
            rem_n   = rem_clr;
            empty_n = 1'b0;
        end
    end

    // state, pending bits and empty flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rem   <= '0;
            empty <= 1'b0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            empty <= empty_n;
        end
    end
`else
    assign out_last = busy && single;

    // next state: a new word takes priority; an empty word is dropped silently
    always_comb begin
        state_n = state;
        rem_n   = rem;
        if (accept) begin
            state_n = (din != '0) ? SCAN : IDLE;
            rem_n   = din;
        end else if (xfer) begin
            state_n = out_last ? IDLE : SCAN;
            rem_n   = rem_clr;
        end
    end

    // state and pending bits registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
        end
    end
`endif

endmodule

// File: doc/bitmap_index_scanner.md
BITMAP_INDEX_SCANNER -- requirements
Module: bitmap_index_scanner

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of scanned bitmap word (>=2, power of two).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  input  1  din carries a word to scan.
REQ-005 Port: in_ready  output  1  scanner accepts din this cycle.
REQ-006 Port: din  input  DATA_WIDTH  bitmap word; bit i set = index i pending.
REQ-007 Port: out_valid  output  1  dout holds a valid index.
REQ-008 Port: out_ready  input  1  consumer accepts dout this cycle.
REQ-009 Port: dout  output  $clog2(DATA_WIDTH)+1  index of lowest pending set bit.
REQ-010 Port: out_last  output  1  current dout is final beat for the accepted word.
REQ-011 Port: busy  output  1  high while in SCAN state.

Function
REQ-012 Two states, IDLE and SCAN; internal register rem[DATA_WIDTH-1:0] holds pending bits.
REQ-013 IDLE: in_ready=1, out_valid=0; in_valid&&in_ready with din!=0 -> rem<=din, state<=SCAN.
REQ-014 IDLE, accepted din==0 (macro off): word consumed, no output beat, stay IDLE.
REQ-015 SCAN: out_valid=1, dout=trailing-zero count of rem, out_last=1 iff rem has exactly one set bit.
REQ-016 SCAN beat transfer (out_valid&&out_ready): rem<=rem & (rem-1) (clear lowest set bit).
REQ-017 SCAN, transfer with out_last=1 -> state<=IDLE unless a new word is accepted same cycle.
REQ-018 in_ready = IDLE || (SCAN && out_ready && out_last); same-cycle final-beat + new-word accept loads rem<=din, stays SCAN (din!=0), no bubble.
REQ-019 Latency: word accepted cycle N -> first out_valid cycle N+1; one index per cycle under continuous out_ready.
REQ-020 Backpressure: out_ready=0 holds dout, out_last, rem, state stable; out_valid never drops without transfer.
REQ-021 Indices emitted strictly ascending; beat count per word equals popcount(din).
REQ-022 dout MSB is 0 for every emitted index (value < DATA_WIDTH) except REQ-027 beat.
REQ-023 busy = (state==SCAN).

Reset
REQ-024 reset=1 at rising edge: state<=IDLE, rem<=0; next cycle out_valid=0, out_last=0, dout=0, busy=0, in_ready=1.
REQ-025 Reset mid-SCAN abandons remaining indices; no partial beat after reset released.
REQ-026 reset has priority over any simultaneous handshake.

Configuration
REQ-027 Macro BITMAP_SCAN_EMPTY_REPORT_EN defined: accepted din==0 produces one beat, dout=DATA_WIDTH, out_last=1, via SCAN state with empty flag.
REQ-028 Macro undefined: REQ-014 applies; empty-flag logic absent.

Structure
REQ-029 Shared package holds: scanner state enum (IDLE, SCAN), index-width constant function/localparam.
REQ-030 One sub-module: tz_count (combinational, DATA_WIDTH parameter, returns DATA_WIDTH for zero input), instanced on rem.
REQ-031 Lowest-bit clear and single-bit detect (rem & (rem-1)==0) computed in the top block.

Verification
REQ-032 din=32'h0000_0091, out_ready=1 -> dout 0,4,7 on cycles N+1..N+3, out_last only on 7, then IDLE.
REQ-033 din=32'h8000_0000 -> single beat dout=31, out_last=1.
REQ-034 din=32'h0000_0006, out_ready low 3 cycles at first beat -> dout=1 held stable, then 1,2.
REQ-035 Back-to-back: din=32'h1 then 32'h3 offered continuously -> beats 0(last),0,1(last), no idle cycle.
REQ-036 din=0: macro off -> no beat, in_ready stays 1; macro on -> one beat dout=32, out_last=1.
REQ-037 reset during SCAN of 32'hFFFF_FFFF after 5 beats -> IDLE next cycle, out_valid=0, rem=0.
